// File: rtl/pulse_xfer_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_xfer_sched_if
// Description : Request/launch bundle between the pseudo-sensor event sources
//               and the pulse-crossing scheduler. The master side drives the
//               requests and controls. The slave side (the scheduler) drives
//               the launch pulse, the launch ID and the status.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_xfer_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0] req_pulse;
  logic               enable;
  logic               ovf_clr;
  logic               launch_pulse;
  logic [ID_W-1:0]    launch_id;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] ovf;
  logic               busy;

  modport master (
    output req_pulse,
    output enable,
    output ovf_clr,
    input  launch_pulse,
    input  launch_id,
    input  pend,
    input  ovf,
    input  busy
  );

  modport slave (
    input  req_pulse,
    input  enable,
    input  ovf_clr,
    output launch_pulse,
    output launch_id,
    output pend,
    output ovf,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/pulse_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module      : pulse_xfer_sched
// Description : Shares one toggle-based pulse crossing between NUM_REQ
//               single-cycle event sources. Each request is latched in a
//               pending bit. An arbiter picks one winner, and the block
//               launches a one-cycle pulse with a held event ID. After every
//               launch it waits GAP_CYCLES+1 cycles so that the downstream
//               toggle synchronizer cannot lose a toggle.
//               Build option PXS_FIXED_PRIO_EN: when defined, the arbiter
//               uses fixed priority (lowest index wins) and has no RR pointer.
//               When undefined (default), the arbiter is round robin.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_xfer_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 6
) (
  input  wire logic         p_clk,
  input  wire logic         arst_p_n,
  pulse_xfer_sched_if.slave bus
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   gap_cnt_nxt;

  logic               launch_q;
  logic [ID_W-1:0]    launch_id_q;
  logic [NUM_REQ-1:0] pend_q;
  logic [NUM_REQ-1:0] ovf_q;
  logic [NUM_REQ-1:0] pend_nxt;
  logic [NUM_REQ-1:0] ovf_nxt;
  logic [NUM_REQ-1:0] lost;

  logic               any_pend;
  logic [ID_W-1:0]    winner;
  logic               grant_vld;
  logic [NUM_REQ-1:0] grant_vec;

`ifdef PXS_FIXED_PRIO_EN
  // Fixed-priority arbiter: the lowest-index pending bit wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    any_pend = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'(k);
      if (!any_pend && pend_q[idx]) begin
        any_pend = 1'b1;
        winner   = idx;
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;

  // Round-robin arbiter: search starts one past the last winner and wraps.
  always_comb begin
    logic [ID_W-1:0] idx;
    any_pend = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_pend && pend_q[idx]) begin
        any_pend = 1'b1;
        winner   = idx;
      end
    end
  end

  // The RR pointer remembers the last winner. The reset value makes requester 0 first.
  always_ff @(posedge p_clk or negedge arst_p_n) begin
    if (!arst_p_n) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (grant_vld) begin
      rr_ptr <= winner;
    end
  end
`endif

  // A grant is only issued from IDLE with launches enabled and work pending.
  always_comb begin
    grant_vld = (state == IDLE) && bus.enable && any_pend;
    grant_vec = grant_vld ? (NUM_REQ'(1) << winner) : '0;
  end

  // Pending/overflow update: a new request always sets pend. A request that
  // finds its bit still pending (and not being granted) is lost. A loss
  // in the same cycle as ovf_clr keeps its flag.
  always_comb begin
    lost     = bus.req_pulse & pend_q & ~grant_vec;
    pend_nxt = bus.req_pulse | (pend_q & ~grant_vec);
    ovf_nxt  = (bus.ovf_clr ? '0 : ovf_q) | lost;
  end

  // Pending and overflow registers.
  always_ff @(posedge p_clk or negedge arst_p_n) begin
    if (!arst_p_n) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  // Next-state logic. GAP lasts GAP_CYCLES+1 cycles, so launches are spaced
  // by at least GAP_CYCLES+2 cycles.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt   = GAP;
          gap_cnt_nxt = CNT_W'(GAP_CYCLES);
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        gap_cnt_nxt = '0;
      end
    endcase
  end

  // State and gap counter registers.
  always_ff @(posedge p_clk or negedge arst_p_n) begin
    if (!arst_p_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Launch pulse lasts one cycle. The ID is held until the next grant so
  // that it stays stable while the pulse crosses the domain.
  always_ff @(posedge p_clk or negedge arst_p_n) begin
    if (!arst_p_n) begin
      launch_q    <= 1'b0;
      launch_id_q <= '0;
    end else begin
      launch_q <= grant_vld;
      if (grant_vld) begin
        launch_id_q <= winner;
      end
    end
  end

  assign bus.launch_pulse = launch_q;
  assign bus.launch_id    = launch_id_q;
  assign bus.pend         = pend_q;
  assign bus.ovf          = ovf_q;
  assign bus.busy         = (state == GAP);

endmodule
`default_nettype wire

// File: tb/tb_pulse_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_xfer_sched
// Description : Random-stimulus bench for pulse_xfer_sched. A cycle-count
//               based reference model provides the expected outputs.
//               Build option PXS_FIXED_PRIO_EN selects the matching arbiter
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_xfer_sched;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int GAP_CYCLES = 6;
  localparam int N_CYCLES   = 4000;

  logic p_clk    = 1'b0;
  logic arst_p_n = 1'b0;

  pulse_xfer_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  pulse_xfer_sched #(
    .NUM_REQ   (NUM_REQ),
    .ID_W      (ID_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .p_clk   (p_clk),
    .arst_p_n(arst_p_n),
    .bus     (bus)
  );

  always #5 p_clk = ~p_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: DUT state is described by cycle numbers, not by a counter.
  bit     m_pend [NUM_REQ];
  bit     m_ovf  [NUM_REQ];
  bit     m_launch;
  int     m_id;
  bit     m_launched_ever;
  longint m_last_launch;
  int     m_last_winner;
  longint m_cyc;

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_pend[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
    m_launch        = 1'b0;
    m_id            = 0;
    m_launched_ever = 1'b0;
    m_last_launch   = 0;
    m_last_winner   = NUM_REQ - 1;
  endtask

  function automatic logic [31:0] pack(input bit v [NUM_REQ]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic bit model_busy();
    return m_launched_ever && ((m_cyc - m_last_launch) <= GAP_CYCLES);
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_step(input logic [NUM_REQ-1:0] req, input bit en, input bit clr);
    bit grant;
    int win;
    int start;
    bit any;
    any = 1'b0;
    win = 0;
`ifdef PXS_FIXED_PRIO_EN
    start = 0;
`else
    start = (m_last_winner + 1) % NUM_REQ;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && m_pend[(start + k) % NUM_REQ]) begin
        any = 1'b1;
        win = (start + k) % NUM_REQ;
      end
    end
    grant = !model_busy() && en && any;
    if (clr) begin
      for (int i = 0; i < NUM_REQ; i++) m_ovf[i] = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (m_pend[i] && !(grant && win == i)) m_ovf[i] = 1'b1;
        m_pend[i] = 1'b1;
      end else if (grant && win == i) begin
        m_pend[i] = 1'b0;
      end
    end
    m_launch = grant;
    if (grant) begin
      m_id            = win;
      m_last_winner   = win;
      m_launched_ever = 1'b1;
      m_last_launch   = m_cyc + 1;
    end
    m_cyc++;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_launch"}, 32'(bus.launch_pulse), 32'(m_launch));
    check({pfx, "_id"},     32'(bus.launch_id),    32'(m_id));
    check({pfx, "_pend"},   32'(bus.pend),         pack(m_pend));
    check({pfx, "_ovf"},    32'(bus.ovf),          pack(m_ovf));
    check({pfx, "_busy"},   32'(bus.busy),         32'(model_busy()));
  endtask

  initial begin
    logic [NUM_REQ-1:0] req;
    bit en;
    bit clr;
    int mid_resets;
    bus.req_pulse = '0;
    bus.enable    = 1'b0;
    bus.ovf_clr   = 1'b0;
    m_cyc         = 0;
    mid_resets    = 0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge p_clk);
    arst_p_n = 1'b1;
    en = 1'b1;

    for (int c = 0; c < N_CYCLES; c++) begin
      @(negedge p_clk);
      check_outputs("run");

      // Asynchronous reset, preferably mid-gap with work still pending.
      if (c > 100 && mid_resets < 8 && model_busy() && pack(m_pend) != 0 &&
          $urandom_range(0, 15) == 0) begin
        mid_resets++;
        bus.req_pulse = '0;
        bus.enable    = 1'b0;
        bus.ovf_clr   = 1'b0;
        arst_p_n      = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        arst_p_n = 1'b1;
        en       = 1'b1;
        model_step('0, 1'b0, 1'b0);
        continue;
      end

      if (c < 60) begin
        // Directed opening: a lone request, then all four at once.
        req = '0;
        if (c == 10) req = 4'b0100;
        if (c == 30) req = 4'b1111;
        en  = 1'b1;
        clr = 1'b0;
      end else begin
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (((c / 200) % 2) == 1) req[i] = ($urandom_range(0, 2) == 0);
          else                      req[i] = ($urandom_range(0, 11) == 0);
        end
        if ($urandom_range(0, 19) == 0) en = ~en;
        clr = ($urandom_range(0, 23) == 0);
      end

      bus.req_pulse = req;
      bus.enable    = en;
      bus.ovf_clr   = clr;
      model_step(req, en, clr);
    end

    @(negedge p_clk);
    check_outputs("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_xfer_sched.md
# pulse_xfer_sched

Round-robin scheduler that shares one toggle-based pulse clock-domain crossing between several single-cycle event sources in the pseudo-sensor source domain. It latches each source's request in a pending bit and picks one winner. It then launches a single-cycle pulse with a stable event ID, and enforces a minimum launch-to-launch gap so the downstream toggle synchronizer never loses a toggle. It sits between the pseudo-sensor event generators and the pulse-crossing `pulse_p` input; `launch_id` crosses as a qualifier bus that is held stable.

## Interface
- `NUM_REQ`, 4, number of requesters; valid range is 2..2^`ID_W`.
- `ID_W`, 2, width of `launch_id`.
- `GAP_CYCLES`, 6, extra idle cycles enforced after every launch; must be ≥1.
- `p_clk` input 1: source-domain clock; the block's only clock.
- `arst_p_n` input 1: asynchronous active-low reset.
- `req_pulse` input `NUM_REQ`: one-cycle event request per source.
- `enable` input 1: when low, no new launch starts.
- `ovf_clr` input 1: clears all `ovf` bits.
- `launch_pulse` output 1: one-cycle pulse that drives the crossing's `pulse_p`.
- `launch_id` output `ID_W`: index of the last launched requester, held until the next launch.
- `pend` output `NUM_REQ`: pending request bits.
- `ovf` output `NUM_REQ`: sticky flag per source, set when a request is lost.
- `busy` output 1: high while in the gap state.

## Operation
- Reset values: `launch_pulse`=0, `launch_id`=0, `pend`=0, `ovf`=0, `busy`=0. State is IDLE, gap counter is 0, and the RR pointer is `NUM_REQ`-1, so requester 0 wins first.
- Pending: `req_pulse[i]` sets `pend[i]` at the next edge.
  - If `pend[i]` is already set and is not being granted that cycle, the request is dropped and `ovf[i]` is set.
  - If `pend[i]` is granted in the same cycle that `req_pulse[i]` is high, the set wins: `pend[i]` stays 1 and `ovf[i]` is not set.
- `ovf` is sticky.
  - `ovf_clr` clears all bits.
  - If a new overflow occurs in the same cycle as `ovf_clr`, the set wins for that bit.
- FSM has two states, IDLE and GAP.
  - IDLE: if `enable` is high and `pend` is nonzero, pick a winner. At the next edge: `launch_pulse`←1, `launch_id`←winner, clear `pend[winner]`, RR pointer←winner, gap counter←`GAP_CYCLES`, state←GAP.
  - GAP: `launch_pulse`←0 after its single cycle. The counter decrements by one per cycle; when it reads 0, state←IDLE.
- Round robin: search starts at pointer+1 and wraps modulo `NUM_REQ`; the first set `pend` bit wins.
- `busy` = (state==GAP).
- `enable` low:
  - No launch is started.
  - A GAP already in progress completes normally.
  - Pending bits keep accumulating.
- Asynchronous reset mid-operation returns every register to its reset value immediately. Pending events are discarded.

## Timing
- Request to launch with the block IDLE and `enable` high: `req_pulse` high in cycle t → `pend` high in t+1 → `launch_pulse` high in t+2, for exactly one cycle.
- `launch_id` changes in the same cycle `launch_pulse` rises and is stable until the next launch.
- Back-to-back launches: the minimum spacing between `launch_pulse` rising cycles is exactly `GAP_CYCLES`+2.
- Integration rule: (`GAP_CYCLES`+2)·T(`p_clk`) ≥ (`SYNC_STAGES`+1)·T(c_clk) of the crossing. `launch_id` must remain stable at least that long, which the gap guarantees.
- `launch_pulse` is never high in two consecutive cycles.

## Configuration
- `PXS_FIXED_PRIO_EN`
  - Defined: the arbiter uses fixed priority, where the lowest index wins. The RR pointer is removed.
  - Undefined (default): round robin as described above.
  - All other behaviour, including timing, is identical in both builds.

## Test plan
- Single request, defaults: `req_pulse`=4'b0100 at cycle 10 → `launch_pulse` high only at cycle 12; `launch_id`=2; `pend`=0 from cycle 12; `busy` high for cycles 12–18.
- All four requesters pulse at cycle 5 → launches at cycles 7, 15, 23, 31 with IDs 0, 1, 2, 3; `ovf`=0. With `PXS_FIXED_PRIO_EN`, the IDs are the same for this case.
- Fairness: `req_pulse[0]` and `req_pulse[1]` re-request immediately after each of their grants → IDs alternate 0, 1, 0, 1. With `PXS_FIXED_PRIO_EN`: req0 re-pulses in the cycle its grant is issued → ID 0 is granted every time, and req1 waits.
- Overflow: `req_pulse[3]` at cycles 3 and 5 while `enable`=0 → `pend[3]`=1 and `ovf[3]`=1 from cycle 6. `ovf_clr` at cycle 9 → `ovf`=0 at cycle 10. A single launch with ID 3 follows once `enable` goes high.
- Enable and gap: `enable` drops during GAP → the gap finishes and `busy` falls, with no further launch. Raising `enable` at cycle E → `launch_pulse` at E+1.
- Reset mid-gap: `arst_p_n` low in the middle of GAP with `pend`=4'b1010 → all outputs are 0 immediately. After release, the next request is served with the same t+2 latency, and requester 0 has first priority.
